de0sopc_nios2_0_nios2_oci_dct_packer: RTL and testbench
=======================================================

// Module: de0sopc_nios2_0_nios2_oci_dct_packer
// PURPOSE
//  Upstream stage of the OCI data-trace path. Packs 2-bit compressed trace
//  atoms (branch/control codes) into a 30-bit buffer with a 4-bit atom count.
//  Emits full or flushed words to the trace FIFO over a valid/ready handshake.
//  Exports the live dct_buffer/dct_count pair to the OCI simulation monitor.
// PARAMETERS
//  ATOM_W  2   bits per trace atom
//  DEPTH   15  atoms per packed word; buffer width = ATOM_W*DEPTH = 30
//  CNT_W   4   width of atom count; must hold 0..DEPTH
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous reset, active-high
//  trace_en     in   1   atom capture enable
//  atom_valid   in   1   atom_code is valid this cycle
//  atom_code    in   2   compressed trace atom
//  flush        in   1   emit partial buffer (single-cycle pulse)
//  out_ready    in   1   downstream FIFO accepts out_word
//  out_valid    out  1   out_word/out_count are valid
//  out_word     out  30  packed atoms; newest atom in [1:0]
//  out_count    out  4   number of valid atoms in out_word (1..15)
//  dct_buffer   out  30  live fill buffer (monitor tap)
//  dct_count    out  4   live fill count (monitor tap)
//  overflow     out  1   sticky: atom dropped, cleared by reset only
// BEHAVIOUR
//  Reset: all outputs 0; fill buffer, count and output register 0; state EMPTY.
//  Accept: atom taken when atom_valid & trace_en & !drop_cond.
//   dct_buffer <= {dct_buffer[27:0], atom_code}; dct_count <= dct_count+1.
//   Atoms with trace_en=0 are ignored silently (no overflow).
//  Output register states: EMPTY (out_valid=0), HOLD (out_valid=1).
//  Emit: fill buffer moves to output register when (count reaches 15 after
//   accept) OR (flush & post-accept count>0), AND state is EMPTY, or HOLD
//   with out_ready=1 in the same cycle. On emit: out_word/out_count load,
//   out_valid=1 next cycle, dct_buffer<=0, dct_count<=0 (plus any atom
//   accepted this same cycle is included in the emitted word, not next one).
//  Latency: 15th atom on cycle N -> out_valid=1 on cycle N+1.
//  HOLD & out_ready & no emit pending -> EMPTY, out_valid=0 next cycle.
//  out_word/out_count stable while out_valid & !out_ready.
//  Full-stall: fill count=15 and output in HOLD with out_ready=0 -> incoming
//   atom dropped (drop_cond), overflow<=1; buffer unchanged.
//  Flush while fill count=0 -> no emit, no state change.
//  Flush while output busy (HOLD, !out_ready) -> flush latched as pending;
//   emit performed on first cycle output frees; pending cleared on emit or if
//   count is 0 at that time.
//  Atom + flush same cycle: atom accepted first, then flushed (count includes it).
//  Count never exceeds 15; no wrap-around; width checks: CNT_W >= clog2(DEPTH+1).
//  Reset mid-operation: buffered and held words are discarded, no partial emit.
// TESTING
//  1. 15 atoms 0,1,2,3,0.. back-to-back, out_ready=1 -> cycle after 15th:
//     out_valid=1, out_count=15, out_word[1:0]=2'd2, out_word[29:28]=2'd0.
//  2. 3 atoms (3,1,2) then flush -> out_count=3, out_word=30'h0000_0036;
//     dct_count=0 next cycle.
//  3. 30 atoms with out_ready=0 -> first word held stable, second fills to 15,
//     atom 31 dropped, overflow=1; raise out_ready -> two words delivered in order.
//  4. Flush with count=0, and atom_valid with trace_en=0 -> no out_valid,
//     dct_count stays 0, overflow stays 0.
//  5. Atom and flush same cycle at count=4 -> out_count=5; flush during HOLD
//     with out_ready=0 -> pending emit fires on cycle after out_ready=1.
//  6. Assert reset mid-fill (count=7) and during HOLD -> all outputs 0
//     same cycle (async), no word emitted after release.

Source files
------------

// File: rtl/de0sopc_nios2_0_nios2_oci_dct_packer.sv
// Packs 2-bit trace atoms into a 15-deep fill buffer and hands full or flushed
// words to the trace FIFO through a one-entry output register (valid/ready).
module de0sopc_nios2_0_nios2_oci_dct_packer #(
  parameter int ATOM_W = 2,
  parameter int DEPTH  = 15,
  parameter int CNT_W  = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trace_en,
  input  logic                    atom_valid,
  input  logic [ATOM_W-1:0]       atom_code,
  input  logic                    flush,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [ATOM_W*DEPTH-1:0] out_word,
  output logic [CNT_W-1:0]        out_count,
  output logic [ATOM_W*DEPTH-1:0] dct_buffer,
  output logic [CNT_W-1:0]        dct_count,
  output logic                    overflow
);

  localparam int BUF_W = ATOM_W * DEPTH;

  generate
    if (CNT_W < $clog2(DEPTH + 1)) begin : g_cnt_w_check
      $error("CNT_W too narrow to hold DEPTH");
    end
  endgenerate

  typedef enum logic {EMPTY = 1'b0, HOLD = 1'b1} state_e;

  state_e             state_q, state_d;
  logic [BUF_W-1:0]   buf_q, buf_d, word_q, emit_word, hold_buf, rest_buf;
  logic [CNT_W-1:0]   cnt_q, cnt_d, ocnt_q, emit_cnt, hold_cnt, rest_cnt;
  logic               pend_q, pend_d, ovf_q, ovf_d;
  logic               full, busy, drop, take, want, emit;

  assign full = (cnt_q == CNT_W'(DEPTH));
  assign busy = (state_q == HOLD) && !out_ready;
  assign drop = atom_valid && trace_en && full && busy;
  assign take = atom_valid && trace_en && !drop;

  // A full buffer left over from a stall goes out whole; a same-cycle atom
  // then starts the next word instead of overrunning this one.
  always_comb begin
    emit_word = buf_q;
    emit_cnt  = cnt_q;
    rest_buf  = '0;
    rest_cnt  = '0;
    want      = 1'b0;
    if (full) begin
      want = 1'b1;
      if (take) begin
        rest_buf = BUF_W'(atom_code);
        rest_cnt = CNT_W'(1);
      end
    end else begin
      if (take) begin
        emit_word = {buf_q[BUF_W-ATOM_W-1:0], atom_code};
        emit_cnt  = cnt_q + CNT_W'(1);
      end
      want = (emit_cnt == CNT_W'(DEPTH)) ||
             ((flush || pend_q) && (emit_cnt != '0));
    end
    hold_buf = emit_word;
    hold_cnt = emit_cnt;
    emit     = want && !busy;
    buf_d    = emit ? rest_buf : hold_buf;
    cnt_d    = emit ? rest_cnt : hold_cnt;
    pend_d   = (flush || pend_q) && !emit && (cnt_d != '0);
    ovf_d    = ovf_q || drop;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (emit) state_d = HOLD;
      HOLD:    if (emit) state_d = HOLD;
               else if (out_ready) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= EMPTY;
      buf_q   <= '0;
      cnt_q   <= '0;
      word_q  <= '0;
      ocnt_q  <= '0;
      pend_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      ovf_q   <= ovf_d;
      if (emit) begin
        word_q <= emit_word;
        ocnt_q <= emit_cnt;
      end
    end
  end

  always_comb begin
    out_valid  = (state_q == HOLD);
    out_word   = word_q;
    out_count  = ocnt_q;
    dct_buffer = buf_q;
    dct_count  = cnt_q;
    overflow   = ovf_q;
  end

endmodule

// File: tb/tb_de0sopc_nios2_0_nios2_oci_dct_packer.sv
// Bench for the trace atom packer: directed scenarios plus random traffic,
// all checked every cycle against a queue-based model of atoms and words.
module tb_de0sopc_nios2_0_nios2_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trace_en = 1'b0;
  logic        atom_valid = 1'b0;
  logic [1:0]  atom_code = 2'd0;
  logic        flush = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [29:0] out_word;
  logic [3:0]  out_count;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0] m_fill[$];
  logic [1:0] m_held[$];
  bit         m_valid, m_pend, m_ovf;

  de0sopc_nios2_0_nios2_oci_dct_packer dut (
    .clk(clk), .reset(reset), .trace_en(trace_en), .atom_valid(atom_valid),
    .atom_code(atom_code), .flush(flush), .out_ready(out_ready),
    .out_valid(out_valid), .out_word(out_word), .out_count(out_count),
    .dct_buffer(dct_buffer), .dct_count(dct_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Model: the fill buffer and held word are lists of atoms, oldest first.
  task automatic model_step(input bit av, input logic [1:0] ac, input bit te,
                            input bit fl, input bit rdy);
    logic [1:0] cand[$];
    logic [1:0] rest[$];
    bit busy, full, acc, want;
    busy = m_valid && !rdy;
    full = (m_fill.size() == 15);
    acc  = av && te && !(full && busy);
    if (av && te && !acc) m_ovf = 1'b1;
    cand = m_fill;
    if (full) begin
      if (acc) rest.push_back(ac);
      want = 1'b1;
    end else begin
      if (acc) cand.push_back(ac);
      want = (cand.size() == 15) || ((fl || m_pend) && cand.size() > 0);
    end
    if (want && !busy) begin
      m_held  = cand;
      m_valid = 1'b1;
      m_fill  = rest;
      m_pend  = 1'b0;
    end else begin
      m_fill = cand;
      m_pend = (fl || m_pend) && (m_fill.size() > 0);
      if (m_valid && rdy) m_valid = 1'b0;
    end
  endtask

  task automatic cmp_model(input string tag);
    logic [29:0] fb, hb;
    fb = '0;
    hb = '0;
    foreach (m_fill[i]) fb = {fb[27:0], m_fill[i]};
    foreach (m_held[i]) hb = {hb[27:0], m_held[i]};
    check({tag, "_valid"}, out_valid, m_valid);
    check({tag, "_dbuf"}, dct_buffer, fb);
    check({tag, "_dcnt"}, dct_count, m_fill.size());
    check({tag, "_ovf"}, overflow, m_ovf);
    if (m_valid) begin
      check({tag, "_word"}, out_word, hb);
      check({tag, "_ocnt"}, out_count, m_held.size());
    end
  endtask

  task automatic step(input bit av, input logic [1:0] ac, input bit te,
                      input bit fl, input bit rdy, input string tag);
    @(negedge clk);
    atom_valid = av;
    atom_code  = ac;
    trace_en   = te;
    flush      = fl;
    out_ready  = rdy;
    model_step(av, ac, te, fl, rdy);
    @(posedge clk);
    #1;
    cmp_model(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    atom_valid = 1'b0;
    flush      = 1'b0;
    reset      = 1'b1;
    #1;
    check({tag, "_valid"}, out_valid, 0);
    check({tag, "_word"}, out_word, 0);
    check({tag, "_ocnt"}, out_count, 0);
    check({tag, "_dbuf"}, dct_buffer, 0);
    check({tag, "_dcnt"}, dct_count, 0);
    check({tag, "_ovf"}, overflow, 0);
    m_fill.delete();
    m_held.delete();
    m_valid = 1'b0;
    m_pend  = 1'b0;
    m_ovf   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [29:0] w1, w2;

  initial begin
    do_reset("rst0");

    // Back-to-back fill to 15 with a free downstream.
    for (int i = 0; i < 15; i++) step(1, 2'(i % 4), 1, 0, 1, "t1");
    check("t1_valid", out_valid, 1);
    check("t1_count", out_count, 15);
    check("t1_lsb", out_word[1:0], 2);
    check("t1_msb", out_word[29:28], 0);
    step(0, 0, 1, 0, 1, "t1_drain");

    // Partial word flushed out.
    step(1, 3, 1, 0, 1, "t2");
    step(1, 1, 1, 0, 1, "t2");
    step(1, 2, 1, 0, 1, "t2");
    step(0, 0, 1, 1, 1, "t2_fl");
    check("t2_word", out_word, 30'h36);
    check("t2_count", out_count, 3);
    check("t2_dcnt", dct_count, 0);
    step(0, 0, 1, 0, 1, "t2_drain");

    // Stalled downstream: second word fills, 31st atom is dropped.
    w1 = '0;
    w2 = '0;
    for (int i = 0; i < 30; i++) begin
      if (i < 15) w1 = {w1[27:0], 2'((i * 3 + 1) % 4)};
      else        w2 = {w2[27:0], 2'((i * 3 + 1) % 4)};
      step(1, 2'((i * 3 + 1) % 4), 1, 0, 0, "t3");
    end
    step(1, 2'd3, 1, 0, 0, "t3_drop");
    check("t3_ovf", overflow, 1);
    check("t3_dcnt", dct_count, 15);
    check("t3_word1", out_word, w1);
    step(0, 0, 1, 0, 1, "t3_rel");
    check("t3_word2", out_word, w2);
    check("t3_valid2", out_valid, 1);
    step(0, 0, 1, 0, 1, "t3_drain");
    check("t3_empty", out_valid, 0);

    // Empty flush and disabled capture do nothing.
    do_reset("rst4");
    step(0, 0, 1, 1, 1, "t4_fl");
    step(1, 2, 0, 0, 1, "t4_dis");
    check("t4_valid", out_valid, 0);
    check("t4_dcnt", dct_count, 0);
    check("t4_ovf", overflow, 0);

    // Atom+flush in one cycle, then a flush deferred by a busy output.
    for (int i = 0; i < 4; i++) step(1, 2'(i), 1, 0, 1, "t5");
    step(1, 2'd1, 1, 1, 0, "t5_af");
    check("t5_count", out_count, 5);
    step(1, 2'd2, 1, 0, 0, "t5");
    step(1, 2'd3, 1, 0, 0, "t5");
    step(0, 0, 1, 1, 0, "t5_pend");
    check("t5_hold", out_count, 5);
    step(0, 0, 1, 0, 1, "t5_fire");
    check("t5_fired", out_count, 2);
    check("t5_fword", out_word, 30'hB);
    step(0, 0, 1, 0, 1, "t5_drain");

    // Reset during a fill and during a held word.
    for (int i = 0; i < 7; i++) step(1, 2'd1, 1, 0, 1, "t6");
    do_reset("t6_rf");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 1, "t6_idle");
    for (int i = 0; i < 15; i++) step(1, 2'd2, 1, 0, 0, "t6h");
    do_reset("t6_rh");
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 1, "t6_idle2");

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset("rnd_rst");
      else step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 2) != 0, "rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
